muldiv: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core, directly upstream of the data-memory stage.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Services MFHI/MFLO onto the EX result path and MTHI/MTLO writes.
- Raises a stall request that the core ORs into AnyStall while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_datapath.sv | 109 ++++++++++
 rtl/muldiv.sv | 116 +++++++++++
 tb/tb_muldiv.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
//   opT    - Op_EX encodings for MULTU/MULT/DIVU/DIV
//   stateT - sequencer states IDLE/MUL/DIV/FIX
//   opIsDiv / opIsSigned - decode helpers used when an operation is accepted
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } opT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } stateT;

  function automatic logic opIsDiv(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic opIsSigned(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: arithmetic core of the multiply/divide unit.
// Operands are reduced to magnitudes on load; one iteration per stepMul/stepDiv
// cycle; resHi/resLo present the sign-corrected result for the FIX cycle.
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   load                latch operands (accept edge)
//   loadDiv, loadSigned operation class of the operation being loaded
//   srcA, srcB          raw rs/rt operands
//   stepMul, stepDiv    perform one shift-add / restoring-divide iteration
//   resHi, resLo        final HI/LO values (combinational, valid in FIX)
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             loadDiv,
  input  logic             loadSigned,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             stepMul,
  input  logic             stepDiv,
  output logic [WIDTH-1:0] resHi,
  output logic [WIDTH-1:0] resLo
);

  // acc holds {upper, lower}: for MUL {partial product, remaining multiplier},
  // for DIV {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   bMag;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rawA;     // unmodified dividend for divide-by-zero
  logic               isDivOp;
  logic               divZero;
  logic               negRes;   // product / quotient sign
  logic               negRem;   // remainder follows dividend sign

  logic               negA, negB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     partial;
  logic               divGe;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] product;

  assign negA = loadSigned & srcA[WIDTH-1];
  assign negB = loadSigned & srcB[WIDTH-1];
  assign magA = negA ? -srcA : srcA;
  assign magB = negB ? -srcB : srcB;

  // Shift-add: conditionally add the multiplicand into the upper half; the
  // carry-out becomes the new MSB as the whole accumulator shifts right.
  assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, bMag} : '0);

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the difference only when it does not go negative.
  assign partial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divGe   = partial >= {1'b0, bMag};
  assign divRem  = divGe ? (partial[WIDTH-1:0] - bMag) : partial[WIDTH-1:0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      acc     <= '0;
      bMag    <= '0;
      rawA    <= '0;
      isDivOp <= 1'b0;
      divZero <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
    end else if (load) begin
      isDivOp <= loadDiv;
      rawA    <= srcA;
      divZero <= loadDiv & (srcB == '0);
      negRes  <= negA ^ negB;
      negRem  <= negA;
      if (loadDiv) begin
        acc  <= {{WIDTH{1'b0}}, magA};
        bMag <= magB;
      end else begin
        acc  <= {{WIDTH{1'b0}}, magB};
        bMag <= magA;
      end
    end else if (stepMul) begin
      acc <= {mulSum, acc[WIDTH-1:1]};
    end else if (stepDiv) begin
      acc <= {divRem, acc[WIDTH-2:0], divGe};
    end
  end

  assign product = negRes ? -acc : acc;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    resHi = product[2*WIDTH-1:WIDTH];
    resLo = product[WIDTH-1:0];
    if (isDivOp) begin
      if (divZero) begin
        resHi = rawA;
        resLo = '1;
      end else begin
        resHi = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        resLo = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Sequencer IDLE -> MUL|DIV (WIDTH iterations) -> FIX (sign fix, HI/LO write).
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   AnyStall                   global stall; blocks acceptance and MT writes
//   Start_EX, Op_EX            start request and operation code
//   SrcA_EX, SrcB_EX           rs / rt operands
//   MfHi_EX, MfLo_EX           MFHI/MFLO read requests
//   MtHi_EX, MtLo_EX           MTHI/MTLO write requests (data SrcA_EX)
//   MDResult_EX                HI/LO read mux onto the EX result path
//   Busy                       operation in flight (MUL, DIV or FIX)
//   StallMD                    stall request while busy and HI/LO is needed
//   Hi, Lo                     architectural HI/LO
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             AnyStall,
  input  logic             Start_EX,
  input  logic [1:0]       Op_EX,
  input  logic [WIDTH-1:0] SrcA_EX,
  input  logic [WIDTH-1:0] SrcB_EX,
  input  logic             MfHi_EX,
  input  logic             MfLo_EX,
  input  logic             MtHi_EX,
  input  logic             MtLo_EX,
  output logic [WIDTH-1:0] MDResult_EX,
  output logic             Busy,
  output logic             StallMD,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  stateT            state, nextState;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             mtEnable;
  logic             request;
  logic             stepMul, stepDiv, writeHiLo;
  logic [WIDTH-1:0] resHi, resLo;

  assign accept   = Start_EX & ~AnyStall & (state == IDLE);
  assign mtEnable = ~AnyStall & (state == IDLE);
  assign request  = Start_EX | MfHi_EX | MfLo_EX | MtHi_EX | MtLo_EX;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:     if (accept) nextState = opIsDiv(Op_EX) ? DIV : MUL;
      MUL, DIV: if (count == LAST) nextState = FIX;
      FIX:      nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Output logic. StallMD stays up through FIX so a dependent MF* waits for
  // the HI/LO write at the end of that cycle.
  always_comb begin
    Busy      = (state != IDLE);
    StallMD   = (state != IDLE) & request;
    stepMul   = (state == MUL);
    stepDiv   = (state == DIV);
    writeHiLo = (state == FIX);
  end

  // Iteration counter: 0..WIDTH-1 while iterating, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset)                         count <= '0;
    else if (stepMul || stepDiv)       count <= (count == LAST) ? '0 : count + 1'b1;
    else                               count <= '0;
  end

  // HI/LO: result write in FIX, MT writes only when idle and unstalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (writeHiLo) begin
      Hi <= resHi;
      Lo <= resLo;
    end else if (mtEnable) begin
      if (MtHi_EX) Hi <= SrcA_EX;
      if (MtLo_EX) Lo <= SrcA_EX;
    end
  end

  assign MDResult_EX = MfHi_EX ? Hi : (MfLo_EX ? Lo : '0);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .loadDiv    (opIsDiv(Op_EX)),
    .loadSigned (opIsSigned(Op_EX)),
    .srcA       (SrcA_EX),
    .srcB       (SrcB_EX),
    .stepMul    (stepMul),
    .stepDiv    (stepDiv),
    .resHi      (resHi),
    .resLo      (resLo)
  );

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: self-checking bench for muldiv (WIDTH=32). Expected HI/LO come
// from directed constants or a plain-arithmetic reference model.
module tb_muldiv;

  localparam int W = 32;
  localparam int BUSY_CYCLES = W + 1;
  localparam int LIMIT = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         AnyStall = 1'b0;
  logic         Start_EX = 1'b0;
  logic [1:0]   Op_EX = 2'd0;
  logic [W-1:0] SrcA_EX = '0;
  logic [W-1:0] SrcB_EX = '0;
  logic         MfHi_EX = 1'b0;
  logic         MfLo_EX = 1'b0;
  logic         MtHi_EX = 1'b0;
  logic         MtLo_EX = 1'b0;
  logic [W-1:0] MDResult_EX;
  logic         Busy;
  logic         StallMD;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  int checks = 0;
  int failures = 0;

  muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .AnyStall    (AnyStall),
    .Start_EX    (Start_EX),
    .Op_EX       (Op_EX),
    .SrcA_EX     (SrcA_EX),
    .SrcB_EX     (SrcB_EX),
    .MfHi_EX     (MfHi_EX),
    .MfLo_EX     (MfLo_EX),
    .MtHi_EX     (MtHi_EX),
    .MtLo_EX     (MtLo_EX),
    .MDResult_EX (MDResult_EX),
    .Busy        (Busy),
    .StallMD     (StallMD),
    .Hi          (Hi),
    .Lo          (Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vecT;

  // Reference: MIPS semantics via 64-bit integer arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: if (b == 0) p = {a, 32'hFFFF_FFFF};
            else        p = {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Present an operation for one cycle; returns at the negedge after accept.
  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    Start_EX = 1'b1;
    Op_EX    = op;
    SrcA_EX  = a;
    SrcB_EX  = b;
    @(negedge clk);
    Start_EX = 1'b0;
  endtask

  // Count negedges with Busy high; bounded so a stuck DUT still terminates.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < LIMIT) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    MfLo_EX = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++;
    if (StallMD !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", StallMD); end
    checks++;
    if (Hi !== '0) begin failures++; $display("FAIL reset_hi: got %h expected 0", Hi); end
    checks++;
    if (Lo !== '0) begin failures++; $display("FAIL reset_lo: got %h expected 0", Lo); end
    checks++;
    if (MDResult_EX !== '0) begin failures++; $display("FAIL reset_mdresult: got %h expected 0", MDResult_EX); end
    reset   = 1'b0;
    MfLo_EX = 1'b0;
  endtask

  task automatic test_directed();
    vecT v[5];
    int cyc;
    v[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[2] = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3] = '{2'd2, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    v[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      startOp(v[i].op, v[i].a, v[i].b);
      waitIdle(cyc);
      checks++;
      if (cyc != BUSY_CYCLES) begin failures++; $display("FAIL directed%0d_busy_cycles: got %0d expected %0d", i, cyc, BUSY_CYCLES); end
      checks++;
      if (Hi !== v[i].hi) begin failures++; $display("FAIL directed%0d_hi: got %h expected %h", i, Hi, v[i].hi); end
      checks++;
      if (Lo !== v[i].lo) begin failures++; $display("FAIL directed%0d_lo: got %h expected %h", i, Lo, v[i].lo); end
      MfHi_EX = 1'b1;
      #1;
      checks++;
      if (MDResult_EX !== v[i].hi) begin failures++; $display("FAIL directed%0d_mfhi: got %h expected %h", i, MDResult_EX, v[i].hi); end
      MfHi_EX = 1'b0;
      MfLo_EX = 1'b1;
      #1;
      checks++;
      if (MDResult_EX !== v[i].lo) begin failures++; $display("FAIL directed%0d_mflo: got %h expected %h", i, MDResult_EX, v[i].lo); end
      MfLo_EX = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, b, eh, el;
    int cyc;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pickOperand();
      b  = pickOperand();
      refModel(op, a, b, eh, el);
      startOp(op, a, b);
      waitIdle(cyc);
      checks++;
      if (cyc != BUSY_CYCLES) begin failures++; $display("FAIL random%0d_busy_cycles: got %0d expected %0d", i, cyc, BUSY_CYCLES); end
      checks++;
      if (Hi !== eh) begin failures++; $display("FAIL random%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, Hi, eh); end
      checks++;
      if (Lo !== el) begin failures++; $display("FAIL random%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, Lo, el); end
    end
  endtask

  task automatic test_stall_mflo();
    logic [W-1:0] a, b, eh, el;
    int stalls;
    int bad;
    a = W'($urandom);
    b = W'($urandom);
    refModel(2'd1, a, b, eh, el);
    startOp(2'd1, a, b);
    MfLo_EX = 1'b1;
    stalls = 0;
    bad = 0;
    while (Busy === 1'b1 && stalls < LIMIT) begin
      if (StallMD !== 1'b1) bad++;
      stalls++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL mflo_stall_held: got %0d unstalled busy cycles expected 0", bad); end
    checks++;
    if (stalls != BUSY_CYCLES) begin failures++; $display("FAIL mflo_stall_cycles: got %0d expected %0d", stalls, BUSY_CYCLES); end
    checks++;
    if (StallMD !== 1'b0) begin failures++; $display("FAIL mflo_release: got %b expected 0", StallMD); end
    checks++;
    if (MDResult_EX !== el) begin failures++; $display("FAIL mflo_value: got %h expected %h", MDResult_EX, el); end
    MfLo_EX = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bad;
    @(negedge clk);
    Start_EX = 1'b1;
    Op_EX    = 2'd0;
    SrcA_EX  = 32'd6;
    SrcB_EX  = 32'd7;
    @(negedge clk);
    // A second start waits in EX for the whole busy period.
    Op_EX   = 2'd2;
    SrcA_EX = 32'd100;
    SrcB_EX = 32'd7;
    cyc = 0;
    bad = 0;
    while (Busy === 1'b1 && cyc < LIMIT) begin
      if (StallMD !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != BUSY_CYCLES) begin failures++; $display("FAIL b2b_first_busy_cycles: got %0d expected %0d", cyc, BUSY_CYCLES); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_start_stall: got %0d unstalled busy cycles expected 0", bad); end
    checks++;
    if (Lo !== 32'd42) begin failures++; $display("FAIL b2b_first_lo: got %h expected %h", Lo, 32'd42); end
    checks++;
    if (Hi !== 32'd0) begin failures++; $display("FAIL b2b_first_hi: got %h expected 0", Hi); end
    @(negedge clk);
    Start_EX = 1'b0;
    waitIdle(cyc);
    checks++;
    if (cyc != BUSY_CYCLES) begin failures++; $display("FAIL b2b_second_busy_cycles: got %0d expected %0d", cyc, BUSY_CYCLES); end
    checks++;
    if (Lo !== 32'd14) begin failures++; $display("FAIL b2b_second_lo: got %h expected %h", Lo, 32'd14); end
    checks++;
    if (Hi !== 32'd2) begin failures++; $display("FAIL b2b_second_hi: got %h expected %h", Hi, 32'd2); end
  endtask

  task automatic test_mt();
    logic [W-1:0] v1, v2, v3, v4, oldHi;
    int cyc;
    v1 = W'($urandom) | 32'h1;
    v2 = ~v1;
    v3 = W'($urandom) | 32'h100;
    v4 = W'($urandom) | 32'h10;
    oldHi = 32'd2;
    // MTHI + MTLO + MFHI in one cycle: read returns old HI, both writes land.
    @(negedge clk);
    MtHi_EX = 1'b1;
    MtLo_EX = 1'b1;
    MfHi_EX = 1'b1;
    SrcA_EX = v1;
    #1;
    checks++;
    if (MDResult_EX !== oldHi) begin failures++; $display("FAIL mt_mfhi_old: got %h expected %h", MDResult_EX, oldHi); end
    @(negedge clk);
    MtHi_EX = 1'b0;
    MtLo_EX = 1'b0;
    MfHi_EX = 1'b0;
    checks++;
    if (Hi !== v1) begin failures++; $display("FAIL mt_hi_write: got %h expected %h", Hi, v1); end
    checks++;
    if (Lo !== v1) begin failures++; $display("FAIL mt_lo_write: got %h expected %h", Lo, v1); end
    // AnyStall blocks both MT writes and operation acceptance.
    AnyStall = 1'b1;
    MtHi_EX  = 1'b1;
    Start_EX = 1'b1;
    Op_EX    = 2'd0;
    SrcA_EX  = v2;
    SrcB_EX  = 32'd3;
    @(negedge clk);
    AnyStall = 1'b0;
    MtHi_EX  = 1'b0;
    Start_EX = 1'b0;
    checks++;
    if (Hi !== v1) begin failures++; $display("FAIL anystall_hi: got %h expected %h", Hi, v1); end
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL anystall_start: got %b expected 0", Busy); end
    // MTLO alone leaves HI untouched.
    MtLo_EX = 1'b1;
    SrcA_EX = v3;
    @(negedge clk);
    MtLo_EX = 1'b0;
    checks++;
    if (Lo !== v3) begin failures++; $display("FAIL mtlo_only_lo: got %h expected %h", Lo, v3); end
    checks++;
    if (Hi !== v1) begin failures++; $display("FAIL mtlo_only_hi: got %h expected %h", Hi, v1); end
    // MTHI during a running operation is stalled, not written.
    startOp(2'd0, 32'd6, 32'd7);
    MtHi_EX = 1'b1;
    SrcA_EX = v4;
    #1;
    checks++;
    if (StallMD !== 1'b1) begin failures++; $display("FAIL mt_busy_stall: got %b expected 1", StallMD); end
    @(negedge clk);
    waitIdle(cyc);
    MtHi_EX = 1'b0;
    checks++;
    if (Hi !== 32'd0) begin failures++; $display("FAIL mt_busy_hi: got %h expected 0", Hi); end
    checks++;
    if (Lo !== 32'd42) begin failures++; $display("FAIL mt_busy_lo: got %h expected %h", Lo, 32'd42); end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    @(negedge clk);
    MtHi_EX = 1'b1;
    MtLo_EX = 1'b1;
    SrcA_EX = 32'h1234_5678;
    @(negedge clk);
    MtHi_EX = 1'b0;
    MtLo_EX = 1'b0;
    startOp(2'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", Busy); end
    checks++;
    if (Hi !== '0) begin failures++; $display("FAIL midreset_hi: got %h expected 0", Hi); end
    checks++;
    if (Lo !== '0) begin failures++; $display("FAIL midreset_lo: got %h expected 0", Lo); end
    reset = 1'b0;
    startOp(2'd0, 32'd6, 32'd7);
    waitIdle(cyc);
    checks++;
    if (cyc != BUSY_CYCLES) begin failures++; $display("FAIL postreset_busy_cycles: got %0d expected %0d", cyc, BUSY_CYCLES); end
    checks++;
    if (Lo !== 32'd42) begin failures++; $display("FAIL postreset_lo: got %h expected %h", Lo, 32'd42); end
    checks++;
    if (Hi !== 32'd0) begin failures++; $display("FAIL postreset_hi: got %h expected 0", Hi); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall_mflo();
    test_back_to_back();
    test_mt();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "timeout");
  end

endmodule
